// File: rtl/nav_pkg.sv
// -----------------------------------------------------------------------------
// nav_pkg
// Shared types and default constants for the navigation profiler.
//   nav_state_t : sequencer states (IDLE, HDNG, MV, DEC, DECF)
//   DEF_*       : default speed constants used by the parameter defaults of
//                 nav_profiler and nav_spd_ramp (11-bit speed domain)
// -----------------------------------------------------------------------------
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDNG = 3'd1,
        MV   = 3'd2,
        DEC  = 3'd3,
        DECF = 3'd4
    } nav_state_t;

    localparam logic [10:0] DEF_MAX_SPD    = 11'h2A0;
    localparam logic [10:0] DEF_MIN_SPD    = 11'h0D0;
    localparam logic [10:0] DEF_INC        = 11'h018;
    localparam logic [10:0] DEF_FUSION_THR = 11'h150;

endpackage

// File: rtl/nav_spd_ramp.sv
// -----------------------------------------------------------------------------
// nav_spd_ramp
// Saturating forward-speed register. All ramp steps are paced by hdng_rdy.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (speed -> 0)
//   load      : load MIN_SPD (takes priority, not paced by hdng_rdy)
//   inc       : accelerate by INC per hdng_rdy, clamped at MAX_SPD
//   dec       : decelerate by INC<<DEC_SHIFT per hdng_rdy, floored at 0
//   decf      : decelerate by INC<<DECF_SHIFT per hdng_rdy, floored at 0
//   hdng_rdy  : pacing strobe
//   spd       : current speed
// -----------------------------------------------------------------------------
module nav_spd_ramp
    import nav_pkg::*;
#(
    parameter int               SPD_W      = 11,
    parameter logic [SPD_W-1:0] MAX_SPD    = SPD_W'(DEF_MAX_SPD),
    parameter logic [SPD_W-1:0] MIN_SPD    = SPD_W'(DEF_MIN_SPD),
    parameter logic [SPD_W-1:0] INC        = SPD_W'(DEF_INC),
    parameter int               DEC_SHIFT  = 1,
    parameter int               DECF_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             decf,
    input  logic             hdng_rdy,
    output logic [SPD_W-1:0] spd
);

    // Decrement steps are kept wide enough that INC<<DECF_SHIFT never
    // truncates, so the floor comparison is exact.
    localparam int             EW        = SPD_W + DECF_SHIFT;
    localparam logic [EW-1:0]  DEC_STEP  = EW'(INC) << DEC_SHIFT;
    localparam logic [EW-1:0]  DECF_STEP = EW'(INC) << DECF_SHIFT;

    logic [SPD_W:0]  sum;
    logic [EW-1:0]   spd_ext;
    logic [EW-1:0]   step;

    assign sum     = {1'b0, spd} + {1'b0, INC};
    assign spd_ext = EW'(spd);
    assign step    = decf ? DECF_STEP : DEC_STEP;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spd <= '0;
        end else if (load) begin
            spd <= MIN_SPD;
        end else if (hdng_rdy) begin
            if (inc) begin
                spd <= (sum > {1'b0, MAX_SPD}) ? MAX_SPD : sum[SPD_W-1:0];
            end else if (dec || decf) begin
                spd <= (spd_ext >= step) ? SPD_W'(spd_ext - step) : '0;
            end
        end
    end

endmodule

// File: rtl/nav_profiler.sv
// -----------------------------------------------------------------------------
// nav_profiler
// Forward-motion / heading sequencer between the command layer and the PID.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   strt_hdng, strt_mv  : start requests, sampled in IDLE only (mv wins)
//   stp_lft, stp_rght   : which side openings qualify as stop points
//   opn_cnt             : qualifying opening to stop at (0 treated as 1)
//   abort               : emergency stop
//   hdng_rdy            : pacing strobe for speed changes and timeout count
//   at_hdng             : heading reached
//   lft_opn, rght_opn   : side IR opening levels
//   frwrd_opn           : forward IR opening level
//   frwrd_spd           : forward speed
//   moving              : sequencer not idle
//   en_fusion           : frwrd_spd above FUSION_THR
//   mv_cmplt, hdng_tmo  : registered one-cycle completion / timeout pulses
// -----------------------------------------------------------------------------
module nav_profiler
    import nav_pkg::*;
#(
    parameter int               SPD_W      = 11,
    parameter logic [SPD_W-1:0] MAX_SPD    = SPD_W'(DEF_MAX_SPD),
    parameter logic [SPD_W-1:0] MIN_SPD    = SPD_W'(DEF_MIN_SPD),
    parameter logic [SPD_W-1:0] INC        = SPD_W'(DEF_INC),
    parameter int               DEC_SHIFT  = 1,
    parameter int               DECF_SHIFT = 3,
    parameter logic [SPD_W-1:0] FUSION_THR = SPD_W'(DEF_FUSION_THR),
    parameter int               CNT_W      = 3,
    parameter int               TMO_W      = 8,
    parameter int               HDNG_TMO   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_hdng,
    input  logic             strt_mv,
    input  logic             stp_lft,
    input  logic             stp_rght,
    input  logic [CNT_W-1:0] opn_cnt,
    input  logic             abort,
    input  logic             hdng_rdy,
    input  logic             at_hdng,
    input  logic             lft_opn,
    input  logic             rght_opn,
    input  logic             frwrd_opn,
    output logic [SPD_W-1:0] frwrd_spd,
    output logic             moving,
    output logic             en_fusion,
    output logic             mv_cmplt,
    output logic             hdng_tmo
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(HDNG_TMO);

    nav_state_t       state, state_nx;
    logic [CNT_W-1:0] rem_cnt, rem_nx;
    logic [TMO_W-1:0] tmo_cnt, tmo_nx;
    logic             lft_prev, rght_prev;
    logic             cmplt_nx, tmo_pls_nx;
    logic             load;
    logic             qual_rise;
    logic             stop_req;
    logic             tmo_hit;
    logic             spd_zero;

    // Simultaneous left and right rises OR together, so they count once.
    assign qual_rise = (stp_lft  & lft_opn  & ~lft_prev) |
                       (stp_rght & rght_opn & ~rght_prev);
    assign stop_req  = abort | ~frwrd_opn;
    assign tmo_hit   = (HDNG_TMO != 0) && (tmo_cnt == TMO_LIM);
    assign spd_zero  = (frwrd_spd == '0);

    // NOTE: every signal written here gets a default first; otherwise any
    // path that skips an assignment would infer a latch.
    always_comb begin
        state_nx   = state;
        rem_nx     = rem_cnt;
        tmo_nx     = tmo_cnt;
        cmplt_nx   = 1'b0;
        tmo_pls_nx = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (strt_mv) begin
                    state_nx = MV;
                    load     = 1'b1;
                    rem_nx   = (opn_cnt == '0) ? CNT_W'(1) : opn_cnt;
                end else if (strt_hdng) begin
                    state_nx = HDNG;
                    tmo_nx   = '0;
                end
            end
            HDNG: begin
                if (hdng_rdy) tmo_nx = tmo_cnt + 1'b1;
                if (at_hdng || abort) begin
                    state_nx = IDLE;
                    cmplt_nx = 1'b1;
                end else if (tmo_hit) begin
                    state_nx   = IDLE;
                    tmo_pls_nx = 1'b1;
                end
            end
            MV: begin
                if (stop_req) begin
                    state_nx = DECF;
                end else if (qual_rise) begin
                    if (rem_cnt == CNT_W'(1)) state_nx = DEC;
                    else                      rem_nx   = rem_cnt - 1'b1;
                end
            end
            DEC: begin
                if (stop_req) begin
                    state_nx = DECF;
                end else if (spd_zero) begin
                    state_nx = IDLE;
                    cmplt_nx = 1'b1;
                end
            end
            DECF: begin
                if (spd_zero) begin
                    state_nx = IDLE;
                    cmplt_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem_cnt   <= '0;
            tmo_cnt   <= '0;
            lft_prev  <= 1'b0;
            rght_prev <= 1'b0;
            mv_cmplt  <= 1'b0;
            hdng_tmo  <= 1'b0;
        end else begin
            state     <= state_nx;
            rem_cnt   <= rem_nx;
            tmo_cnt   <= tmo_nx;
            lft_prev  <= lft_opn;
            rght_prev <= rght_opn;
            mv_cmplt  <= cmplt_nx;
            hdng_tmo  <= tmo_pls_nx;
        end
    end

    nav_spd_ramp #(
        .SPD_W      (SPD_W),
        .MAX_SPD    (MAX_SPD),
        .MIN_SPD    (MIN_SPD),
        .INC        (INC),
        .DEC_SHIFT  (DEC_SHIFT),
        .DECF_SHIFT (DECF_SHIFT)
    ) u_ramp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .inc      (state == MV),
        .dec      (state == DEC),
        .decf     (state == DECF),
        .hdng_rdy (hdng_rdy),
        .spd      (frwrd_spd)
    );

    assign moving    = (state != IDLE);
    assign en_fusion = (frwrd_spd > FUSION_THR);

endmodule

// File: tb/tb_nav_profiler.sv
// -----------------------------------------------------------------------------
// tb_nav_profiler
// Scoreboard bench for nav_profiler (default parameters). Stimulus is applied
// on the falling edge; a reference model predicts the outputs after the next
// rising edge and queues them; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_nav_profiler;

    localparam int MAX_SPD   = 'h2A0;
    localparam int MIN_SPD   = 'h0D0;
    localparam int INC       = 'h018;
    localparam int DEC_STEP  = INC * 2;
    localparam int DECF_STEP = INC * 8;
    localparam int FUS_THR   = 'h150;
    localparam int TMO_LIM   = 200;

    localparam int M_IDLE = 0, M_HDNG = 1, M_MV = 2, M_DEC = 3, M_DECF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght, abort, hdng_rdy;
    logic        at_hdng, lft_opn, rght_opn, frwrd_opn;
    logic [2:0]  opn_cnt;
    logic [10:0] frwrd_spd;
    logic        moving, en_fusion, mv_cmplt, hdng_tmo;

    always #5 clk = ~clk;

    nav_profiler dut (
        .clk       (clk),
        .rst       (rst),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .opn_cnt   (opn_cnt),
        .abort     (abort),
        .hdng_rdy  (hdng_rdy),
        .at_hdng   (at_hdng),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .frwrd_spd (frwrd_spd),
        .moving    (moving),
        .en_fusion (en_fusion),
        .mv_cmplt  (mv_cmplt),
        .hdng_tmo  (hdng_tmo)
    );

    typedef struct packed {
        logic [10:0] spd;
        logic        mov;
        logic        fus;
        logic        cmp;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_mode, m_spd, m_rem, m_tcnt;
    bit m_lp, m_rp, m_cmp, m_tmo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_spd = 0; m_rem = 0; m_tcnt = 0;
        m_lp = 0; m_rp = 0; m_cmp = 0; m_tmo = 0;
    endtask

    // Predicts the outputs after the next rising edge from the current inputs.
    task automatic model_step();
        int old_spd = m_spd;
        bit rise_l  = lft_opn  && !m_lp;
        bit rise_r  = rght_opn && !m_rp;
        bit qual    = (stp_lft && rise_l) || (stp_rght && rise_r);
        bit halt    = abort || !frwrd_opn;
        exp_t e;
        m_lp = lft_opn; m_rp = rght_opn;
        m_cmp = 0; m_tmo = 0;
        case (m_mode)
            M_IDLE: begin
                if (strt_mv) begin
                    m_mode = M_MV; m_spd = MIN_SPD;
                    m_rem  = (opn_cnt == 0) ? 1 : int'(opn_cnt);
                end else if (strt_hdng) begin
                    m_mode = M_HDNG; m_tcnt = 0;
                end
            end
            M_HDNG: begin
                if (at_hdng || abort)      begin m_mode = M_IDLE; m_cmp = 1; end
                else if (m_tcnt == TMO_LIM) begin m_mode = M_IDLE; m_tmo = 1; end
                if (hdng_rdy) m_tcnt++;
            end
            M_MV: begin
                if (hdng_rdy) m_spd = (old_spd + INC > MAX_SPD) ? MAX_SPD : old_spd + INC;
                if (halt) m_mode = M_DECF;
                else if (qual) begin
                    if (m_rem == 1) m_mode = M_DEC;
                    else            m_rem--;
                end
            end
            M_DEC: begin
                if (hdng_rdy) m_spd = (old_spd - DEC_STEP < 0) ? 0 : old_spd - DEC_STEP;
                if (halt) m_mode = M_DECF;
                else if (old_spd == 0) begin m_mode = M_IDLE; m_cmp = 1; end
            end
            default: begin
                if (hdng_rdy) m_spd = (old_spd - DECF_STEP < 0) ? 0 : old_spd - DECF_STEP;
                if (old_spd == 0) begin m_mode = M_IDLE; m_cmp = 1; end
            end
        endcase
        e.spd = 11'(m_spd);
        e.mov = (m_mode != M_IDLE);
        e.fus = (m_spd > FUS_THR);
        e.cmp = m_cmp;
        e.tmo = m_tmo;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        strt_hdng = 0; strt_mv = 0; stp_lft = 0; stp_rght = 0; abort = 0;
        hdng_rdy = 0; at_hdng = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
        opn_cnt = 0;
    endtask

    // Monitor: compare every post-edge output against the queued prediction.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                checks++;
                if (frwrd_spd !== mon_e.spd || moving !== mon_e.mov ||
                    en_fusion !== mon_e.fus || mv_cmplt !== mon_e.cmp ||
                    hdng_tmo !== mon_e.tmo) begin
                    errors++;
                    $display("FAIL sb @%0t: got spd=%h mov=%b fus=%b cmp=%b tmo=%b expected spd=%h mov=%b fus=%b cmp=%b tmo=%b",
                             $time, frwrd_spd, moving, en_fusion, mv_cmplt, hdng_tmo,
                             mon_e.spd, mon_e.mov, mon_e.fus, mon_e.cmp, mon_e.tmo);
                end
            end
        end
    end

    initial begin
        rst = 1;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_spd",    frwrd_spd, 0);
        check("reset_moving", moving,    0);
        check("reset_cmplt",  mv_cmplt,  0);
        check("reset_tmo",    hdng_tmo,  0);
        rst = 0;
        step();

        // Acceleration clamp and en_fusion threshold
        strt_mv = 1; step(); strt_mv = 0;
        check("accel_load", frwrd_spd, 'h0D0);
        hdng_rdy = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 5)  check("fusion_low",  en_fusion, 0);
            if (i == 6)  check("fusion_high", en_fusion, 1);
            if (i == 19) check("accel_19",    frwrd_spd, 'h298);
            if (i == 20) check("accel_20",    frwrd_spd, 'h2A0);
        end
        step(); step();
        check("accel_clamp", frwrd_spd, 'h2A0);

        // Fast stop on loss of forward opening
        hdng_rdy = 0; frwrd_opn = 0; step();
        hdng_rdy = 1;
        step(); check("decf_1", frwrd_spd, 'h1E0);
        step(); check("decf_2", frwrd_spd, 'h120);
        step(); check("decf_3", frwrd_spd, 'h060);
        step(); check("decf_4", frwrd_spd, 'h000);
        check("decf_still_moving", moving, 1);
        hdng_rdy = 0; step();
        check("decf_cmplt",  mv_cmplt, 1);
        check("decf_moving", moving,   0);
        frwrd_opn = 1; step();
        check("cmplt_one_cycle", mv_cmplt, 0);

        // Stop at the third left opening, then normal decel
        opn_cnt = 3; stp_lft = 1; strt_mv = 1; step(); strt_mv = 0; opn_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            lft_opn = 1; step(); step();
            lft_opn = 0; step();
        end
        hdng_rdy = 1;
        step(); check("dec_step", frwrd_spd, 'h0A0);
        for (int i = 0; i < 6; i++) step();
        hdng_rdy = 0; step(); step();
        stp_lft = 0;

        // Simultaneous rises count once; abort escalates DEC to DECF
        opn_cnt = 1; stp_lft = 1; stp_rght = 1; strt_mv = 1; step();
        strt_mv = 0; opn_cnt = 0;
        hdng_rdy = 1; for (int i = 0; i < 10; i++) step(); hdng_rdy = 0;
        lft_opn = 1; rght_opn = 1; step(); step();
        hdng_rdy = 1; step(); hdng_rdy = 0;
        abort = 1; step(); abort = 0;
        hdng_rdy = 1; for (int i = 0; i < 4; i++) step();
        hdng_rdy = 0; step(); step();
        quiet_inputs(); step();

        // Heading timeout
        strt_hdng = 1; step(); strt_hdng = 0;
        hdng_rdy = 1; for (int i = 0; i < TMO_LIM; i++) step();
        hdng_rdy = 0; step();
        check("tmo_pulse",     hdng_tmo, 1);
        check("tmo_no_cmplt",  mv_cmplt, 0);
        check("tmo_spd_held",  frwrd_spd, 0);
        step();

        // Heading reached at strobe 50
        strt_hdng = 1; step(); strt_hdng = 0;
        hdng_rdy = 1; for (int i = 0; i < 49; i++) step();
        at_hdng = 1; step(); at_hdng = 0; hdng_rdy = 0;
        check("hdng_cmplt", mv_cmplt, 1);
        check("hdng_no_tmo", hdng_tmo, 0);
        step();

        // Reset mid-move at 0x1A8
        strt_mv = 1; step(); strt_mv = 0;
        hdng_rdy = 1; for (int i = 0; i < 9; i++) step(); hdng_rdy = 0;
        check("pre_rst_spd", frwrd_spd, 'h1A8);
        rst = 1; model_reset();
        #1;
        check("rst_async_spd",    frwrd_spd, 0);
        check("rst_async_moving", moving,    0);
        @(negedge clk);
        rst = 0;
        step(); step();

        // Both starts together: move wins
        strt_mv = 1; strt_hdng = 1; step(); strt_mv = 0; strt_hdng = 0;
        check("both_start_spd", frwrd_spd, 'h0D0);
        abort = 1; step(); abort = 0;
        hdng_rdy = 1; for (int i = 0; i < 3; i++) step(); hdng_rdy = 0;
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            strt_mv   = ($urandom_range(0, 7) == 0);
            strt_hdng = ($urandom_range(0, 7) == 0);
            opn_cnt   = 3'($urandom_range(0, 7));
            stp_lft   = $urandom_range(0, 1);
            stp_rght  = $urandom_range(0, 1);
            abort     = ($urandom_range(0, 99) == 0);
            hdng_rdy  = $urandom_range(0, 1);
            at_hdng   = ($urandom_range(0, 15) == 0);
            frwrd_opn = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) lft_opn  = ~lft_opn;
            if ($urandom_range(0, 3) == 0) rght_opn = ~rght_opn;
            step();
        end
        quiet_inputs();
        step(); step();
        check("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nav_profiler.md
# nav_profiler

Parametrised forward-motion and heading sequencer for the maze runner, sitting between the command layer (strt_mv/strt_hdng/stop requests) and the PID/inertial integrator. It generates the unsigned forward-speed ramp, `moving` and `en_fusion` gating, and completion pulses. Over the first-generation navigator it adds:

- generic speed width and ramp rates;
- stop at the Nth qualifying side opening;
- an abort input;
- DEC→DECF escalation;
- a heading-timeout pulse.

## Interface

Parameters:
- SPD_W, 11: width of frwrd_spd
- MAX_SPD, 11'h2A0: speed ceiling; acceleration clamps here
- MIN_SPD, 11'h0D0: speed loaded on strt_mv
- INC, 11'h018: acceleration step per hdng_rdy
- DEC_SHIFT, 1: normal decel step = INC<<DEC_SHIFT
- DECF_SHIFT, 3: fast decel step = INC<<DECF_SHIFT
- FUSION_THR, 11'h150: en_fusion threshold
- CNT_W, 3: width of opn_cnt
- TMO_W, 8: width of heading-timeout counter
- HDNG_TMO, 200: hdng_rdy pulses allowed in heading; 0 disables timeout

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- strt_hdng  in  1  start heading change (sampled in IDLE only)
- strt_mv  in  1  start forward move (sampled in IDLE only)
- stp_lft  in  1  left openings qualify as stop points
- stp_rght  in  1  right openings qualify as stop points
- opn_cnt  in  CNT_W  qualifying opening to stop at; latched on strt_mv; 0 treated as 1
- abort  in  1  emergency stop request
- hdng_rdy  in  1  pacing strobe for all speed changes and the timeout count
- at_hdng  in  1  heading reached (from PID)
- lft_opn  in  1  left IR opening level
- rght_opn  in  1  right IR opening level
- frwrd_opn  in  1  forward IR opening level
- frwrd_spd  out  SPD_W  forward speed; reset 0
- moving  out  1  state≠IDLE; reset 0
- en_fusion  out  1  frwrd_spd>FUSION_THR, combinational; reset 0
- mv_cmplt  out  1  registered one-cycle completion pulse; reset 0
- hdng_tmo  out  1  registered one-cycle heading-timeout pulse; reset 0

## Operation

States are IDLE, HDNG, MV, DEC and DECF.

- **IDLE**
  - strt_mv wins over strt_hdng when both are asserted.
  - strt_mv → MV. frwrd_spd←MIN_SPD; remaining count←max(opn_cnt,1).
  - strt_hdng → HDNG. Timeout counter←0.
- **HDNG**
  - Timeout counter increments on each hdng_rdy.
  - at_hdng → IDLE and mv_cmplt.
  - Otherwise abort → IDLE and mv_cmplt.
  - Otherwise, when HDNG_TMO≠0 and the counter reaches HDNG_TMO → IDLE and hdng_tmo (mv_cmplt is not asserted).
- **MV**
  - On hdng_rdy: frwrd_spd←min(frwrd_spd+INC, MAX_SPD).
  - A qualifying rise is (stp_lft & lft rise) | (stp_rght & rght rise). Simultaneous left and right rises count once.
  - Priority: abort or !frwrd_opn → DECF; then a qualifying rise with remaining count==1 → DEC; then a qualifying rise decrements the remaining count.
- **DEC**
  - On hdng_rdy: subtract INC<<DEC_SHIFT, floored at 0.
  - abort or !frwrd_opn → DECF (escalation).
  - Otherwise frwrd_spd==0 → IDLE and mv_cmplt.
- **DECF**
  - On hdng_rdy: subtract INC<<DECF_SHIFT, floored at 0.
  - frwrd_spd==0 → IDLE and mv_cmplt.
- **Arithmetic**
  - Decrement steps are computed at SPD_W+DECF_SHIFT bits.
  - Compare before subtract; never wrap.
  - Add is compared against MAX_SPD; never exceeds it.
- **Edge detectors**
  - lft/rght previous-value flops update every cycle and reset to 0.
  - Rises are used only in MV.
- **Misc**
  - frwrd_spd is held in IDLE and HDNG.
  - strt_* and opn_cnt are ignored outside IDLE.

## Timing

- strt_mv high at edge k: state=MV and frwrd_spd=MIN_SPD after edge k. First increment occurs at the first hdng_rdy after that.
- Speed updates take effect on the edge that samples hdng_rdy.
- mv_cmplt/hdng_tmo are high exactly the first cycle in IDLE after the exit edge. A new strt_* in that cycle is accepted.
- The exit from DEC/DECF uses registered frwrd_spd==0, so it occurs one cycle after speed reaches 0.
- Rise detection has 1-cycle latency: the state change happens on the edge following the first high sample.
- rst mid-operation forces IDLE, all outputs 0, counters 0, immediately (asynchronous).

## Structure

- Package nav_pkg holds:
  - nav_state_t enum (IDLE, HDNG, MV, DEC, DECF);
  - default speed constants (MAX_SPD, MIN_SPD, INC, FUSION_THR) used by the parameter defaults.
- Sub-module nav_spd_ramp: the saturating speed register with inputs load, inc, dec, decf and hdng_rdy, parametrised as above.
- The FSM, opening counter, timeout counter and edge detectors stay in nav_profiler.

## Test plan

Defaults are used throughout.

- **Acceleration clamp:** strt_mv, frwrd_opn=1, 20 hdng_rdy → frwrd_spd 0x0D0, 0x0E8 … 0x298 after 19 strobes, 0x2A0 after the 20th, stays 0x2A0. en_fusion rises when frwrd_spd first exceeds 0x150 (0x160).
- **Fast stop:** at 0x2A0 drop frwrd_opn → DECF; 0x1E0, 0x120, 0x060, 0x000 on 4 strobes; mv_cmplt one pulse one cycle after reaching 0; moving falls with it.
- **Nth opening:** opn_cnt=3, stp_lft=1, three lft_opn pulses → first two ignored, DEC after the third; step 0x30 per strobe to 0; mv_cmplt.
- **Simultaneous/escalation:** opn_cnt=1, stp_lft=stp_rght=1, both rise same cycle → one DEC entry. Then abort mid-DEC → DECF, step 0xC0.
- **Heading:** strt_hdng with at_hdng held 0 for 200 hdng_rdy → hdng_tmo pulse, no mv_cmplt, frwrd_spd unchanged. Repeat with at_hdng at strobe 50 → mv_cmplt only.
- **Reset mid-move:** rst pulse in MV at 0x1A8 → frwrd_spd=0, IDLE, no completion pulse. Also strt_mv+strt_hdng together → MV.
